// File: rtl/nibble_packer_pkg.sv
// Shared constants and helpers for the nibble packer slice.
package nibble_packer_pkg;

  localparam int unsigned NIBBLE_W        = 4;
  localparam int unsigned DEFAULT_NIBBLES = 4;

  // Width needed to encode a nibble count in the range 0..n.
  function automatic int unsigned len_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO holding packed words with their lengths.
module word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;

  // Head reads as zero whenever nothing is buffered.
  always_comb begin
    o_rdata_c = '0;
    if (!o_empty_c) begin
      o_rdata_c = r_mem[r_rd_ptr];
    end
  end

  // Storage, power-of-two wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// Packs a stream of nibbles into words (first nibble at the LSBs) and
// buffers completed or flushed words for a valid/ready consumer.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int unsigned NIBBLES    = DEFAULT_NIBBLES,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NIBBLE_W-1:0]             in_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]     out_data,
  output logic [$clog2(NIBBLES+1)-1:0]    out_len
);

  localparam int unsigned WORD_W  = NIBBLE_W * NIBBLES;
  localparam int unsigned LEN_W   = len_w(NIBBLES);
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned ENTRY_W = WORD_W + LEN_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [IDX_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_asm;
  logic [WORD_W-1:0]  w_asm_next;
  logic [LEN_W-1:0]   w_len;
  logic               w_accept;
  logic               w_last;
  logic               w_flush;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;

  assign in_ready = !rst && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_last   = w_accept && (r_idx == IDX_W'(NIBBLES - 1));
  assign w_flush  = flush && in_ready && ((r_idx != '0) || w_accept);
  assign w_push   = w_last || w_flush;
  assign w_len    = LEN_W'(r_idx) + LEN_W'(w_accept);

  // Assembly word with the incoming nibble dropped into its slot; unused
  // upper slots are already zero because the register clears on every push.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (w_accept && (r_idx == IDX_W'(k))) begin
        w_asm_next[k*NIBBLE_W +: NIBBLE_W] = in_data;
      end
    end
  end

  // Slot index and assembly register; both restart after any push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (w_push) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (w_accept) begin
      r_idx <= r_idx + IDX_W'(1);
      r_asm <= w_asm_next;
    end
  end

  word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (out_ready),
    .i_wdata   ({w_len, w_asm_next}),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head[WORD_W-1:0];
  assign out_len   = w_head[ENTRY_W-1:WORD_W];

  logic w_unused;
  assign w_unused = ^w_count;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: directed nibble streams push their
// hand-computed words into a queue, a negedge monitor pops and compares.
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_len;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  len;
  } exp_t;

  exp_t sb[$];

  nibble_packer #(.NIBBLES(4), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_word(input logic [15:0] d, input logic [2:0] l);
    exp_t e;
    e.data = d;
    e.len  = l;
    sb.push_back(e);
  endfunction

  // Monitor: compares the FIFO head on every pop, plus idle-zero and hold stability.
  logic        hold = 1'b0;
  logic [15:0] hold_data;
  logic [2:0]  hold_len;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_len", 32'(out_len), 32'(hold_len));
      end
      if (!out_valid) begin
        check("idle_data_zero", 32'(out_data), 32'h0);
        check("idle_len_zero", 32'(out_len), 32'h0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", 32'(out_data), 32'(e.data));
          check("word_len", 32'(out_len), 32'(e.len));
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_len  = out_len;
    end
  end

  // Present one beat and hold it until the packer is ready; returns at posedge+1.
  task automatic send(input logic [3:0] d, input logic f, input logic v);
    bit ok;
    in_valid = v;
    in_data  = d;
    flush    = f;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 32'(ok), 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_len", 32'(out_len), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Full word back-to-back, one-cycle latency.
    expect_word(16'h4321, 3'd4);
    send(4'h1, 1'b0, 1'b1);
    send(4'h2, 1'b0, 1'b1);
    send(4'h3, 1'b0, 1'b1);
    send(4'h4, 1'b0, 1'b1);
    check("latency_valid", 32'(out_valid), 32'h1);
    wait_drain();

    // Flush alone after two nibbles, then a full word.
    expect_word(16'h00BA, 3'd2);
    send(4'hA, 1'b0, 1'b1);
    send(4'hB, 1'b0, 1'b1);
    send(4'h0, 1'b1, 1'b0);
    expect_word(16'hFEDC, 3'd4);
    send(4'hC, 1'b0, 1'b1);
    send(4'hD, 1'b0, 1'b1);
    send(4'hE, 1'b0, 1'b1);
    send(4'hF, 1'b0, 1'b1);
    wait_drain();

    // Flush together with the completing nibble: exactly one word.
    expect_word(16'h5321, 3'd4);
    send(4'h1, 1'b0, 1'b1);
    send(4'h2, 1'b0, 1'b1);
    send(4'h3, 1'b0, 1'b1);
    send(4'h5, 1'b1, 1'b1);
    idle(3);
    wait_drain();

    // Flush with a partial-word accept in the same cycle.
    expect_word(16'h0076, 3'd2);
    send(4'h6, 1'b0, 1'b1);
    send(4'h7, 1'b1, 1'b1);
    wait_drain();

    // Backpressure: two words fill the FIFO and in_ready drops.
    out_ready = 1'b0;
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    expect_word(16'hCBA9, 3'd4);
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, 1'b1);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_out_valid", 32'(out_valid), 32'h1);
    check("full_head", 32'(out_data), 32'h4321);
    in_valid = 1'b1; in_data = 4'h9;
    idle(2);
    out_ready = 1'b1;
    send(4'h9, 1'b0, 1'b1);
    send(4'hA, 1'b0, 1'b1);
    send(4'hB, 1'b0, 1'b1);
    send(4'hC, 1'b0, 1'b1);
    wait_drain();

    // Flush at slot 0 with nothing accepted is a no-op.
    send(4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("noop_flush_valid", 32'(out_valid), 32'h0);
    idle(2);

    // Reset mid-word with a buffered word discards everything.
    out_ready = 1'b0;
    send(4'h1, 1'b0, 1'b1);
    send(4'h2, 1'b0, 1'b1);
    send(4'h3, 1'b0, 1'b1);
    send(4'h4, 1'b0, 1'b1);
    send(4'h7, 1'b0, 1'b1);
    send(4'h8, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_valid", 32'(out_valid), 32'h0);
    check("after_rst_data", 32'(out_data), 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_word(16'h4321, 3'd4);
    send(4'h1, 1'b0, 1'b1);
    send(4'h2, 1'b0, 1'b1);
    send(4'h3, 1'b0, 1'b1);
    send(4'h4, 1'b0, 1'b1);
    wait_drain();
    idle(3);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
